mem_access_ctrl: RTL and testbench



---
 rtl/mem_ctrl_pkg.sv | 26 ++
 rtl/mem_wait_counter.sv | 34 +++
 rtl/mem_access_ctrl.sv | 157 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the memory access controller.
// Contents:
//   state_e      - access sequencer states (IDLE, SETUP, ACCESS, HOLD)
//   op_e         - latched operation (OP_RD, OP_WR)
//   DEF_ADDR_W   - default address width (matches the address register output)
//   DEF_DATA_W   - default memory data word width
//   CNT_W        - width of the access wait counter
package mem_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W = 15;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times the strobe phase of a memory access.
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - synchronous active-low reset (count -> 0)
//   load     - load load_val (has priority over dec)
//   dec      - decrement by one; saturates at zero
//   load_val - value loaded on load
//   zero     - high while the count is zero
module mem_wait_counter
    import mem_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: turns a CPU read/write request into a timed
// SETUP / ACCESS / HOLD strobe sequence on an asynchronous SRAM-style port,
// captures read data and reports completion with a one-cycle done pulse.
//
// Optional build macro MEM_ACCESS_CTRL_PARITY_EN adds write parity generation
// and read parity checking (ports mem_wpar, mem_rpar, par_err).
//
// Ports:
//   clk, rst_n          - clock (rising edge), synchronous active-low reset
//   addr, wdata         - request address / write data, latched in IDLE
//   re, we             - request levels, sampled only in IDLE (we wins)
//   busy               - high whenever not IDLE
//   done               - one-cycle completion pulse (during HOLD)
//   rdata              - last captured read word
//   mem_addr/mem_wdata - memory address / write data
//   mem_rdata          - memory read data
//   mem_ce/oe/wr       - chip enable, output enable, write strobe
//   mem_wpar, mem_rpar, par_err - parity option only
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic              we,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_ACCESS_CTRL_PARITY_EN
    output logic              mem_wpar,
    input  logic              mem_rpar,
    output logic              par_err,
`endif
    output logic              mem_ce,
    output logic              mem_oe,
    output logic              mem_wr
);

    localparam logic [CNT_W-1:0] WaitLoad = CNT_W'(WAIT_CYCLES);

    state_e state_q, state_d;
    op_e    op_q, op_d;

    logic              busy_q, done_q;
    logic              mem_ce_q, mem_oe_q, mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic cnt_load, cnt_dec, cnt_zero;
    logic start;
    logic last_access;

    assign start       = (state_q == IDLE) && (we || re);
    assign last_access = (state_q == ACCESS) && cnt_zero;
    assign cnt_load    = (state_q == SETUP);
    assign cnt_dec     = (state_q == ACCESS) && !cnt_zero;

    mem_wait_counter u_wait_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (WaitLoad),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    op_d    = we ? OP_WR : OP_RD;
                end
            end
            SETUP:   state_d = ACCESS;
            ACCESS:  if (cnt_zero) state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe, without a combinational path to the pins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_RD;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_ce_q    <= 1'b0;
            mem_oe_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_d == HOLD);
            mem_ce_q <= (state_d != IDLE);
            mem_oe_q <= (state_d == ACCESS) && (op_d == OP_RD);
            mem_wr_q <= (state_d == ACCESS) && (op_d == OP_WR);
            if (start) begin
                mem_addr_q  <= addr;
                mem_wdata_q <= wdata;
            end
            if (last_access && (op_q == OP_RD)) begin
                rdata_q <= mem_rdata;
            end
        end
    end

`ifdef MEM_ACCESS_CTRL_PARITY_EN
    logic mem_wpar_q, par_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_wpar_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            // Latched with wdata, so this is the parity of the latched word.
            if (start) begin
                mem_wpar_q <= we ? (^wdata) : 1'b0;
            end
            if (last_access) begin
                par_err_q <= (op_q == OP_RD) ? ((^mem_rdata) ^ mem_rpar) : 1'b0;
            end
        end
    end

    assign mem_wpar = mem_wpar_q;
    assign par_err  = par_err_q;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_ce    = mem_ce_q;
    assign mem_oe    = mem_oe_q;
    assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl (WAIT_CYCLES = 1). Stimulus pushes the
// expected completion (cycle, address, data, rdata) into a queue; a monitor
// pops and checks it whenever done is seen.
module tb_mem_access_ctrl;

    localparam int W = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic        busy, done;
    logic [15:0] rdata;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ce, mem_oe, mem_wr;
    logic [15:0] mem_word = '0;
`ifdef MEM_ACCESS_CTRL_PARITY_EN
    logic        mem_wpar, par_err;
    logic        mem_rpar = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        int          done_cyc;
        logic [14:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        par;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model drives data only while output-enabled.
    assign mem_rdata = mem_oe ? mem_word : 16'h0000;

    mem_access_ctrl #(
        .ADDR_W      (15),
        .DATA_W      (16),
        .WAIT_CYCLES (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (addr),
        .wdata     (wdata),
        .re        (re),
        .we        (we),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
`ifdef MEM_ACCESS_CTRL_PARITY_EN
        .mem_wpar  (mem_wpar),
        .mem_rpar  (mem_rpar),
        .par_err   (par_err),
`endif
        .mem_ce    (mem_ce),
        .mem_oe    (mem_oe),
        .mem_wr    (mem_wr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending access (cyc %0d)",
                         cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
                chk("done_addr", 32'(mem_addr), 32'(e.addr));
                chk("done_wdata", 32'(mem_wdata), 32'(e.wdata));
                chk("done_rdata", 32'(rdata), 32'(e.rdata));
                chk("done_busy", 32'(busy), 32'd1);
`ifdef MEM_ACCESS_CTRL_PARITY_EN
                chk("done_par_err", 32'(par_err), 32'(e.par));
`endif
            end
        end
    end

    // One complete access with per-cycle strobe checks.
    task automatic run_op(input logic w, input logic r, input logic [14:0] a,
                          input logic [15:0] d, input logic [15:0] exp_rdata,
                          input logic exp_par, input logic exp_wpar);
        int k;
        exp_t e;
        @(negedge clk);
        we = w; re = r; addr = a; wdata = d;
        k = cyc + 1;
        e.done_cyc = k + 2 + W; e.addr = a; e.wdata = d; e.rdata = exp_rdata; e.par = exp_par;
        exp_q.push_back(e);
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        addr = ~a; wdata = ~d;
        chk("setup_ce", 32'(mem_ce), 32'd1);
        chk("setup_strobes", 32'({mem_oe, mem_wr}), 32'd0);
        chk("setup_busy", 32'(busy), 32'd1);
        for (int i = 0; i <= W; i++) begin
            @(negedge clk);
            chk("access_wr", 32'(mem_wr), 32'(w));
            chk("access_oe", 32'(mem_oe), 32'(!w));
            chk("access_addr", 32'(mem_addr), 32'(a));
            if (w) chk("access_wdata", 32'(mem_wdata), 32'(d));
`ifdef MEM_ACCESS_CTRL_PARITY_EN
            chk("access_wpar", 32'(mem_wpar), 32'(exp_wpar));
`endif
        end
        @(negedge clk);
        chk("hold_ce", 32'(mem_ce), 32'd1);
        chk("hold_strobes", 32'({mem_oe, mem_wr}), 32'd0);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ce", 32'(mem_ce), 32'd0);
        chk("idle_rdata", 32'(rdata), 32'(exp_rdata));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        exp_t e;

        // Reset, then idle outputs.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_strobes", 32'({mem_ce, mem_oe, mem_wr}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", 32'(busy), 32'd0);

        // Write, read, then simultaneous request (write wins).
        run_op(1'b1, 1'b0, 15'h1234, 16'hBEEF, 16'h0000, 1'b0, 1'b1);
        mem_word = 16'hA5A5;
        run_op(1'b0, 1'b1, 15'h7FFF, 16'h0000, 16'hA5A5, 1'b0, 1'b0);
        mem_word = 16'h0F0F;
        run_op(1'b1, 1'b1, 15'h0042, 16'h1111, 16'hA5A5, 1'b0, 1'b0);

        // Request while busy is ignored; the held level starts a new access
        // only after an idle cycle. Input changes mid-access have no effect.
        @(negedge clk);
        we = 1'b1; addr = 15'h0200; wdata = 16'h2222;
        k = cyc + 1;
        e.done_cyc = k + 2 + W; e.addr = 15'h0200; e.wdata = 16'h2222;
        e.rdata = 16'hA5A5; e.par = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        addr = 15'h0001; wdata = 16'h3333;
        e.done_cyc = k + 6 + 2 * W; e.addr = 15'h0001; e.wdata = 16'h3333;
        exp_q.push_back(e);
        @(negedge clk);
        chk("busy_addr_stable", 32'(mem_addr), 32'h0200);
        repeat (W + 1) @(negedge clk);
        chk("busy_hold_addr", 32'(mem_addr), 32'h0200);
        chk("busy_hold_wdata", 32'(mem_wdata), 32'h2222);
        @(negedge clk);
        chk("gap_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        we = 1'b0;
        chk("second_busy", 32'(busy), 32'd1);
        chk("second_addr", 32'(mem_addr), 32'h0001);
        repeat (W + 3) @(negedge clk);
        chk("second_idle", 32'(busy), 32'd0);

        // Reset during the first ACCESS cycle of a read.
        mem_word = 16'h1357;
        @(negedge clk);
        re = 1'b1; addr = 15'h0300;
        @(negedge clk);
        re = 1'b0;
        @(negedge clk);
        chk("pre_rst_oe", 32'(mem_oe), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_strobes", 32'({mem_ce, mem_oe, mem_wr}), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_rdata", 32'(rdata), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_quiet", 32'(busy), 32'd0);
        mem_word = 16'h5A5A;
        run_op(1'b0, 1'b1, 15'h0100, 16'h0000, 16'h5A5A, 1'b0, 1'b0);

`ifdef MEM_ACCESS_CTRL_PARITY_EN
        run_op(1'b1, 1'b0, 15'h0010, 16'h0001, 16'h5A5A, 1'b0, 1'b1);
        mem_word = 16'h0003; mem_rpar = 1'b1;
        run_op(1'b0, 1'b1, 15'h0011, 16'h0000, 16'h0003, 1'b1, 1'b0);
        chk("par_err_held", 32'(par_err), 32'd1);
        mem_rpar = 1'b0;
        run_op(1'b0, 1'b1, 15'h0012, 16'h0000, 16'h0003, 1'b0, 1'b0);
        mem_rpar = 1'b1;
        run_op(1'b0, 1'b1, 15'h0013, 16'h0000, 16'h0003, 1'b1, 1'b0);
        run_op(1'b1, 1'b0, 15'h0014, 16'h0003, 16'h0003, 1'b0, 1'b0);
        chk("par_err_wr_clear", 32'(par_err), 32'd0);
`endif

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
